// File: rtl/lustre_fby_n.sv
// Lustre "init -> pre^D(next)" operator on a sampled clock: a D-deep delay line
// with a fill counter that selects init_val until D instants have elapsed.
module lustre_fby_n #(
  parameter int N  = 1,
  parameter int D  = 1,
  parameter int CW = $clog2(D + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic         init,
  input  logic [N-1:0] init_val,
  input  logic [N-1:0] next_val,
  output logic [N-1:0] res,
  output logic         primed
);

  localparam logic [CW-1:0] CNT_MAX = CW'(D);

  logic [N-1:0]  sr [D];
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      // NOTE: the delay line is cleared on reset so the history is deterministic after restart.
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's old value.
      sr[0] <= next_val;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      if (init) begin
        cnt <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A restart masks stale history on the very instant it is requested.
  assign res    = (init || (cnt < CNT_MAX)) ? init_val : sr[D-1];
  assign primed = (cnt == CNT_MAX) && !init;

endmodule

// File: tb/tb_lustre_fby_n.sv
// Directed bench for lustre_fby_n: D=3/N=8, D=1/N=8 and D=7/N=1 instances on one clock.
module tb_lustre_fby_n;

  logic clock = 1'b0;
  logic reset_n;

  logic       en3, init3, pr3;
  logic [7:0] iv3, nv3, res3;
  logic       en1, init1, pr1;
  logic [7:0] iv1, nv1, res1;
  logic       en7, init7, iv7, nv7, res7, pr7;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  lustre_fby_n #(.N(8), .D(3)) u_d3 (
    .clock(clock), .reset_n(reset_n), .en(en3), .init(init3),
    .init_val(iv3), .next_val(nv3), .res(res3), .primed(pr3)
  );

  lustre_fby_n #(.N(8), .D(1)) u_d1 (
    .clock(clock), .reset_n(reset_n), .en(en1), .init(init1),
    .init_val(iv1), .next_val(nv1), .res(res1), .primed(pr1)
  );

  lustre_fby_n #(.N(1), .D(7)) u_d7 (
    .clock(clock), .reset_n(reset_n), .en(en7), .init(init7),
    .init_val(iv7), .next_val(nv7), .res(res7), .primed(pr7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Applies one cycle on the D=3 instance, checks outputs before the edge, then clocks.
  task automatic step3(input string tag, input logic e, input logic i, input logic [7:0] nv,
                       input logic [7:0] exp_res, input logic exp_pr);
    en3 = e; init3 = i; nv3 = nv;
    #1;
    check({tag, " res"}, 32'(res3), 32'(exp_res));
    check({tag, " primed"}, 32'(pr3), 32'(exp_pr));
    @(posedge clock); #1;
  endtask

  task automatic step1(input string tag, input logic i, input logic [7:0] nv,
                       input logic [7:0] exp_res, input logic exp_pr);
    en1 = 1'b1; init1 = i; nv1 = nv;
    #1;
    check({tag, " res"}, 32'(res1), 32'(exp_res));
    check({tag, " primed"}, 32'(pr1), 32'(exp_pr));
    @(posedge clock); #1;
  endtask

  initial begin
    logic [19:0] pat;
    pat = 20'b1011_0011_1000_1101_0110;

    reset_n = 1'b0;
    en3 = 1'b0; init3 = 1'b0; iv3 = 8'hFF; nv3 = 8'h00;
    en1 = 1'b0; init1 = 1'b0; iv1 = 8'd9;  nv1 = 8'h00;
    en7 = 1'b0; init7 = 1'b0; iv7 = 1'b1;  nv7 = 1'b0;
    #2;
    check("rst d3 res", 32'(res3), 32'hFF);
    check("rst d3 primed", 32'(pr3), 32'd0);
    check("rst d1 res", 32'(res1), 32'd9);
    check("rst d7 res", 32'(res7), 32'd1);
    check("rst d7 primed", 32'(pr7), 32'd0);
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Fill from reset
    step3("fill0", 1, 0, 8'd10, 8'hFF, 0);
    step3("fill1", 1, 0, 8'd11, 8'hFF, 0);
    step3("fill2", 1, 0, 8'd12, 8'hFF, 0);
    step3("fill3", 1, 0, 8'd13, 8'd10, 1);
    step3("fill4", 1, 0, 8'd14, 8'd11, 1);

    // Restart mid-stream discards history
    step3("rst0", 1, 1, 8'd20, 8'hFF, 0);
    step3("rst1", 1, 0, 8'd21, 8'hFF, 0);
    step3("rst2", 1, 0, 8'd22, 8'hFF, 0);
    step3("rst3", 1, 0, 8'd23, 8'd20, 1);

    // Gated activation: en=0 values never enter, init with en=0 does not restart
    step3("gate0", 1, 0, 8'd30, 8'd21, 1);
    step3("gate1", 0, 0, 8'd31, 8'd22, 1);
    step3("gate2", 0, 1, 8'd32, 8'hFF, 0);
    step3("gate3", 1, 0, 8'd33, 8'd22, 1);
    step3("gate4", 1, 0, 8'd34, 8'd23, 1);
    step3("gate5", 1, 0, 8'd35, 8'd30, 1);
    step3("gate6", 1, 0, 8'd36, 8'd33, 1);

    // Asynchronous reset between edges
    en3 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async res", 32'(res3), 32'hFF);
    check("async primed", 32'(pr3), 32'd0);
    iv3 = 8'hA5;
    #1;
    check("async iv follow", 32'(res3), 32'hA5);
    iv3 = 8'hFF;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    step3("rep0", 1, 0, 8'd40, 8'hFF, 0);
    step3("rep1", 1, 0, 8'd41, 8'hFF, 0);
    step3("rep2", 1, 0, 8'd42, 8'hFF, 0);
    step3("rep3", 1, 0, 8'd43, 8'd40, 1);
    en3 = 1'b0;

    // D=1 single-stage fby
    step1("d1 post-rst", 0, 8'd3, 8'd9, 0);
    step1("d1 init", 1, 8'd5, 8'd9, 0);
    step1("d1 s1", 0, 8'd6, 8'd5, 1);
    step1("d1 s2", 0, 8'd7, 8'd6, 1);
    en1 = 1'b0;

    // D=7 saturation over 20 instants
    for (int k = 0; k < 20; k++) begin
      en7 = 1'b1; init7 = 1'b0; nv7 = pat[k];
      #1;
      check($sformatf("d7 res k=%0d", k), 32'(res7), (k < 7) ? 32'(iv7) : 32'(pat[k-7]));
      check($sformatf("d7 primed k=%0d", k), 32'(pr7), (k < 7) ? 32'd0 : 32'd1);
      @(posedge clock); #1;
    end
    en7 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lustre_fby_n.md
LUSTRE_FBY_N -- requirements
Module: lustre_fby_n

Interface
REQ-001 Parameter N, default 1: data width in bits; the legal range SHALL be N >= 1.
REQ-002 Parameter D, default 1: delay depth in activations; the legal range SHALL be D >= 1.
REQ-003 Parameter CW, default $clog2(D+1): width of the fill counter, derived from D; CW SHALL NOT be overridden.
REQ-004 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the reset, asynchronous assert, active-low, synchronous deassert (released by the system).
REQ-006 en  input  1  SHALL be the activation (Lustre sampled clock); 1 = current cycle is an instant of the node.
REQ-007 init  input  1  SHALL restart the stream; 1 = current instant is instant 0.
REQ-008 init_val  input  N  SHALL be the value emitted during the first D instants.
REQ-009 next_val  input  N  SHALL be the stream value sampled at each active instant.
REQ-010 res  output  N  SHALL be the result stream: init_val -> pre^D(next_val).
REQ-011 primed  output  1  SHALL be high once D instants have elapsed since the last restart/reset.

Function
REQ-012 State SHALL consist of a D-entry shift register sr[0..D-1] (N bits each, sr[0] newest) and a fill counter cnt (0..D).
REQ-013 res SHALL be combinational: init_val when init=1 or cnt<D, else sr[D-1]; zero latency from init/init_val/state to res.
REQ-014 primed SHALL be combinational: 1 iff cnt==D and init=0.
REQ-015 On a rising edge with en=1: sr[0]<=next_val, sr[i]<=sr[i-1] for i=1..D-1.
REQ-016 On a rising edge with en=1 and init=1: cnt<=1 (current instant counted as instant 0); the shift of REQ-015 SHALL also occur.
REQ-017 On a rising edge with en=1 and init=0: cnt<=min(cnt+1, D); cnt SHALL saturate at D, never wrap.
REQ-018 On a rising edge with en=0: sr and cnt SHALL hold; init and next_val SHALL have no effect on state.
REQ-019 With en=0, res and primed SHALL still follow REQ-013/REQ-014 combinationally from held state and current init.
REQ-020 Resulting semantics: at active instant k since restart, res = init_val for k<D, res = next_val sampled at instant k-D for k>=D.
REQ-021 For D=1, en tied 1, behaviour SHALL match a single-stage fby: res = init ? init_val : previous next_val, except that res = init_val on the first cycle after reset without init.
REQ-022 Restart mid-stream (init=1 with cnt=D) SHALL discard history: res = init_val for the next D instants including the current one, regardless of sr contents.
REQ-023 Counter arithmetic SHALL be unsigned CW bits; D=2^k-1 SHALL NOT overflow (cnt max = D fits in CW).

Reset
REQ-024 While reset_n=0: cnt=0 and all sr entries = 0, asynchronously, independent of clock and en.
REQ-025 During and after reset, res SHALL equal init_val and primed SHALL be 0 until D active instants have elapsed.
REQ-026 Reset asserted mid-operation SHALL take effect immediately on res (next evaluation yields init_val) without waiting for a clock edge.
REQ-027 First rising edge with reset_n=1 SHALL behave per REQ-015..REQ-018 with cnt=0 as prior state.

Verification (N=8, D=3 unless noted)
REQ-028 Reset then en=1, init=0, next_val=10,11,12,13,14, init_val=0xFF -> res = FF,FF,FF,10,11; primed 0,0,0,1,1.
REQ-029 Stream primed (cnt=3), init=1 at instant with next_val=20, then 21,22,23 -> res = FF,FF,FF,20; primed 0 on the init cycle.
REQ-030 Primed stream, en pattern 1,0,0,1 with next_val changing every cycle -> res and sr unchanged across en=0 cycles; the en=0 next_val values never appear on res.
REQ-031 Primed stream, reset_n pulsed low between edges -> res = init_val immediately, primed=0; after release, 3 active instants to re-prime.
REQ-032 D=1, en=1, init=1 first cycle then 0, next_val=5,6,7, init_val=9 -> res = 9,5,6.
REQ-033 D=7, N=1: run 20 active instants -> cnt saturates at 7, no wrap, primed stays 1, res = next_val delayed by 7.
